// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state type and default width for alu_seq
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiplier (shift-subtract divider under ALU_SEQ_DIV_EN)
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

`ifdef ALU_SEQ_DIV_EN
    logic             mode_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_diff;
`else
    logic             unused_mode;
    assign unused_mode = mode;
`endif

    assign busy = (count != '0);
    assign done = (count == CW'(1));
    // hi/lo expose the value after the current step so the caller can
    // capture the final result on the same edge the counter reaches zero.
    assign hi   = hi_nxt;
    assign lo   = lo_nxt;

    // One iteration step: multiply shifts {acc, multiplier} right with a
    // conditional add; divide shifts {rem, quotient} left with a trial subtract.
    always_comb begin
        add_sum = {1'b0, hi_q} + {1'b0, m_q};
        hi_nxt  = hi_q;
        lo_nxt  = lo_q;
`ifdef ALU_SEQ_DIV_EN
        shifted  = {hi_q, lo_q[WIDTH-1]};
        sub_diff = shifted - {1'b0, m_q};
        if (mode_q) begin
            if (!sub_diff[WIDTH]) begin
                hi_nxt = sub_diff[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else
`endif
        begin
            if (lo_q[0]) begin
                {hi_nxt, lo_nxt} = {add_sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_nxt, lo_nxt} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    // Operand load on start, then one step per cycle until the counter drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
`ifdef ALU_SEQ_DIV_EN
            mode_q <= 1'b0;
`endif
        end else if (start) begin
            count <= CW'(WIDTH);
            hi_q  <= '0;
`ifdef ALU_SEQ_DIV_EN
            mode_q <= mode;
            m_q    <= mode ? op_b : op_a;
            lo_q   <= mode ? op_a : op_b;
`else
            m_q   <= op_a;
            lo_q  <= op_b;
`endif
        end else if (busy) begin
            count <= count - CW'(1);
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU top; ALU_SEQ_DIV_EN adds DIVU
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_zero,
    output logic             flag_ovf,
    output logic             flag_err
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             multi_op;
    logic             eng_start;
    logic             eng_mode;
    logic             eng_busy;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_err;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign eng_start = accept && multi_op;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (eng_start),
        .op_a  (operand1),
        .op_b  (operand2),
        .mode  (eng_mode),
        .busy  (eng_busy),
        .done  (eng_done),
        .hi    (eng_hi),
        .lo    (eng_lo)
    );

    // Single-cycle datapath and decode of which ops go to the iterative engine.
    always_comb begin
        shamt    = operand2[SHW-1:0];
        sum      = operand1 + operand2;
        diff     = operand1 - operand2;
        sc_res   = '0;
        sc_hi    = '0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        multi_op = 1'b0;
        eng_mode = 1'b0;
        case (alu_ctrl)
            OP_AND: sc_res = operand1 & operand2;
            OP_OR:  sc_res = operand1 | operand2;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                         (sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                         (diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            OP_SLL: sc_res = operand1 << shamt;
            OP_SRL: sc_res = operand1 >> shamt;
            OP_SRA: sc_res = $signed(operand1) >>> shamt;
            OP_MULTU: multi_op = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                if (operand2 == '0) begin
                    sc_res = '1;
                    sc_hi  = operand1;
                    sc_err = 1'b1;
                end else begin
                    multi_op = 1'b1;
                    eng_mode = 1'b1;
                end
            end
`endif
            default: sc_err = 1'b1;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accepts from IDLE or DONE, BUSY runs until the engine finishes.
    always_comb begin
        state_nxt = state;
        if (state == BUSY) begin
            if (eng_done) begin
                state_nxt = DONE;
            end else if (!eng_busy) begin
                state_nxt = IDLE;
            end
        end else if (accept) begin
            state_nxt = multi_op ? BUSY : DONE;
        end else if (state == DONE && out_ready) begin
            state_nxt = IDLE;
        end
    end

    // Result registers: loaded on a single-cycle accept or on engine completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= '0;
            res_hi    <= '0;
            flag_zero <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_err  <= 1'b0;
        end else if (accept && !multi_op) begin
            res       <= sc_res;
            res_hi    <= sc_hi;
            flag_zero <= (sc_res == '0);
            flag_ovf  <= sc_ovf;
            flag_err  <= sc_err;
        end else if (eng_done) begin
            res       <= eng_lo;
            res_hi    <= eng_hi;
            flag_zero <= (eng_lo == '0);
            flag_ovf  <= 1'b0;
            flag_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (define ALU_SEQ_DIV_EN to cover DIVU)
module tb_alu_seq;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        o;
        logic        e;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  alu_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic [31:0] res_hi;
    logic        flag_zero;
    logic        flag_ovf;
    logic        flag_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_hi    (res_hi),
        .flag_zero (flag_zero),
        .flag_ovf  (flag_ovf),
        .flag_err  (flag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every result transfer pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got res=%0h hi=%0h with empty scoreboard", res, res_hi);
            end else begin
                mon_e = sb.pop_front();
                if (res !== mon_e.res || res_hi !== mon_e.hi || flag_zero !== mon_e.z ||
                    flag_ovf !== mon_e.o || flag_err !== mon_e.e) begin
                    errors++;
                    $display("FAIL %s: got res=%0h hi=%0h z=%0b o=%0b e=%0b expected res=%0h hi=%0h z=%0b o=%0b e=%0b",
                             mon_e.nm, res, res_hi, flag_zero, flag_ovf, flag_err,
                             mon_e.res, mon_e.hi, mon_e.z, mon_e.o, mon_e.e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present an op and hold it until accepted; returns #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eres, input logic [31:0] ehi,
                         input logic ez, input logic eo, input logic ee, input string nm);
        exp_t e;
        logic rdy;
        int   n;
        if (push) begin
            e.res = eres; e.hi = ehi; e.z = ez; e.o = eo; e.e = ee; e.nm = nm;
            sb.push_back(e);
        end
        alu_ctrl = op;
        operand1 = a;
        operand2 = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_%s: got in_ready=0 expected 1", nm);
        end
    endtask

    // Counts cycles from accept to out_valid, tracking in_ready during BUSY.
    task automatic wait_result(input string nm, input int exp_lat);
        int lat;
        bit ready_seen;
        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_busy_in_ready"}, 64'(ready_seen), 64'd0);
    endtask

    initial begin
        bit hold_ok;
        bit seen_valid;
        int n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operand1  = '0;
        operand2  = '0;
        alu_ctrl  = '0;
        out_ready = 1'b1;
        idle(3);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", {32'(res | res_hi), 29'd0, flag_zero, flag_ovf, flag_err}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Reset during a multiply aborts it.
        issue(4'b1000, 32'd3, 32'd5, 1'b0, 0, 0, 0, 0, 0, "mul_abort");
        idle(4);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_outputs", {32'(res | res_hi), 29'd0, flag_zero, flag_ovf, flag_err}, 64'd0);
        idle(2);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_result", 64'(seen_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);

        // Single-cycle ops, issued back to back.
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 0, 0, 1, 0, "add_ovf");
        check("add_latency", 64'(out_valid), 64'd1);
        issue(4'b0010, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 0, 1, 1, 0, "add_ovf_zero");
        issue(4'b0011, 32'd5, 32'd5, 1'b1, 32'h0, 0, 1, 0, 0, "sub_zero");
        issue(4'b0011, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 0, 0, 1, 0, "sub_ovf");
        issue(4'b0111, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, 0, 0, 0, 0, "sra");
        issue(4'b0110, 32'h8000_0000, 32'd4, 1'b1, 32'h0800_0000, 0, 0, 0, 0, "srl");
        issue(4'b0101, 32'h1, 32'd31, 1'b1, 32'h8000_0000, 0, 0, 0, 0, "sll_31");
        issue(4'b0101, 32'hABCD_1234, 32'd32, 1'b1, 32'hABCD_1234, 0, 0, 0, 0, "sll_0");
        issue(4'b0100, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h1, 0, 0, 0, 0, "slt_true");
        issue(4'b0100, 32'h1, 32'hFFFF_FFFF, 1'b1, 32'h0, 0, 1, 0, 0, "slt_false");
        issue(4'b1111, 32'h1234, 32'h5678, 1'b1, 32'h0, 0, 1, 0, 1, "illegal");

        // Multiply.
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'hFFFF_FFFE, 0, 0, 0, "mul_max");
        wait_result("mul_max", 32);
        issue(4'b1000, 32'd3, 32'd5, 1'b1, 32'd15, 32'h0, 0, 0, 0, "mul_small");
        wait_result("mul_small", 32);
        issue(4'b1000, 32'h1234_5678, 32'h10, 1'b1, 32'h2345_6780, 32'h1, 0, 0, 0, "mul_carry");
        wait_result("mul_carry", 32);

`ifdef ALU_SEQ_DIV_EN
        issue(4'b1001, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 0, 0, 0, "divu");
        wait_result("divu", 32);
        issue(4'b1001, 32'h1234, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 0, 0, 1, "divu_zero");
        check("divu_zero_latency", 64'(out_valid), 64'd1);
`else
        issue(4'b1001, 32'd100, 32'd7, 1'b1, 32'h0, 32'h0, 1, 0, 1, "divu_illegal");
        check("divu_illegal_latency", 64'(out_valid), 64'd1);
`endif

        // Backpressure then back-to-back accept.
        idle(3);
        out_ready = 1'b0;
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 0, 0, 0, 0, "and_held");
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || in_ready || res !== 32'hF000_F000) hold_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check("backpressure_hold", 64'(hold_ok), 64'd1);
        out_ready = 1'b1;
        issue(4'b0001, 32'h0F, 32'hF0, 1'b1, 32'hFF, 0, 0, 0, 0, "or_b2b");
        check("b2b_res", 64'(res), 64'hFF);
        check("b2b_valid", 64'(out_valid), 64'd1);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle MIPS datapath ALU.
- Executes logical, arithmetic, compare and shift ops with a 1-cycle registered latency.
- Executes unsigned multiply iteratively over WIDTH cycles, writing a double-width HI/LO result.
- Sits between the ID/EX operand latch and the EX/MEM stage; the pipeline stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block accepts an op this cycle.
- operand1  in  WIDTH  A operand.
- operand2  in  WIDTH  B operand; shift amount is operand2[SHW-1:0].
- alu_ctrl  in  4  opcode.
- out_valid  out  1  result registers hold a completed op.
- out_ready  in  1  consumer takes the result.
- res  out  WIDTH  result; LO word for multiply.
- res_hi  out  WIDTH  HI word for multiply, 0 for other ops.
- flag_zero  out  1  res == 0.
- flag_ovf  out  1  signed overflow; ADD/SUB only.
- flag_err  out  1  illegal opcode (or divide by zero, see below).

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB.
  - 0100 SLT: signed, res = {0..,1} or 0.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 MULTU.
  - 1001 DIVU, only when the macro is defined.
  - All other codes: res = 0, res_hi = 0, flag_err = 1, single-cycle.
- Reset (async on rst_n low): state IDLE; res, res_hi and all flags = 0; out_valid = 0; iteration counter = 0. Reset mid-multiply aborts it; no result is produced.
- States:
  - IDLE: accepting.
  - BUSY: iterating.
  - DONE: result held.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Accept at edge N when in_valid && in_ready.
- Single-cycle op:
  - Result and flags registered at edge N.
  - State goes to DONE; out_valid = 1 after edge N.
- MULTU:
  - Operands latched at edge N; state goes to BUSY, counter = WIDTH.
  - One shift-add step per edge; counter decrements.
  - At the edge where the counter goes 1 -> 0: {res_hi, res} = operand1 * operand2 (unsigned, 2*WIDTH bits), state goes to DONE.
  - out_valid = 1 after edge N + WIDTH.
- DONE:
  - Result, flags and out_valid held stable while out_ready = 0.
  - out_ready && !in_valid -> IDLE, out_valid = 0.
  - out_ready && in_valid: the next op is accepted at the same edge (back-to-back). A single-cycle op gives throughput 1/cycle.
- BUSY: in_ready = 0; in_valid and operands are ignored.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - flag_ovf = operand sign bits meet the overflow condition (ADD: same signs, result differs; SUB: signs differ, result sign != operand1 sign).
- Shifts: shift amounts >= WIDTH cannot occur (only SHW bits are used); a shift by 0 returns operand1.
- flag_zero is computed on res only, for all ops including MULTU.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: opcode 1001 DIVU runs restoring division in the BUSY state, WIDTH cycles, same timing as MULTU.
  - res = quotient, res_hi = remainder.
  - operand2 == 0: single-cycle completion, res = all ones, res_hi = operand1, flag_err = 1.
- Undefined: 1001 is an illegal opcode (flag_err = 1, res = 0). No divider hardware is present.

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams (OP_AND .. OP_DIVU).
  - State typedef (IDLE/BUSY/DONE).
  - Default WIDTH constant.
- Sub-module alu_muldiv_iter: WIDTH-parametrised iterative shift-add engine, with the shift-subtract path under the macro.
  - Ports: start, operands, mode, busy, done, hi, lo.
- The top level owns the handshake FSM, the single-cycle ops and the output registers.

Test Plan:
- Reset mid-multiply:
  - Stimulus: MULTU 3*5 accepted, rst_n pulsed low 4 cycles later.
  - Response: out_valid = 0 and all outputs 0 immediately; no result after release; in_ready = 1.
- ADD overflow:
  - Stimulus: WIDTH = 32, ADD 0x7FFFFFFF + 1.
  - Response: one cycle later res = 0x80000000, flag_ovf = 1, flag_zero = 0.
  - Also: SUB 5 - 5 gives res = 0, flag_zero = 1.
- Shifts and SLT:
  - SRA 0x80000000 by 4 gives 0xF8000000.
  - SRL by 4 gives 0x08000000.
  - SLT 0xFFFFFFFF vs 1 gives res = 1.
- MULTU:
  - Stimulus: 0xFFFFFFFF * 0xFFFFFFFF.
  - Response: out_valid exactly 32 cycles after accept; res_hi = 0xFFFFFFFE, res = 0x00000001; in_ready = 0 throughout BUSY.
- Backpressure and back-to-back:
  - Stimulus: out_ready = 0 for 5 cycles after an AND result.
  - Response: result held stable. Then out_ready = 1 with a queued OR: the OR is accepted on the same edge, and its result is valid on the next cycle.
- Illegal opcode and divide (run with and without ALU_SEQ_DIV_EN):
  - Opcode 1111: flag_err = 1, res = 0.
  - DIVU 100/7 with the macro: res = 14, res_hi = 2 after 32 cycles.
  - DIVU x/0 with the macro: flag_err = 1.
  - Without the macro, 1001 behaves as illegal.
